// File: rtl/dma_down_arbiter_pkg.sv
// Shared types and elaboration helpers for the DMA down packet arbiter.
package dma_down_arbiter_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int unsigned MIN_INPUTS = 2;
    localparam int unsigned MAX_INPUTS = 16;

    function automatic int unsigned sel_width(input int unsigned n);
        if (n <= 1) return 1;
        return $clog2(n);
    endfunction

    function automatic bit inputs_in_range(input int unsigned n);
        return (n >= MIN_INPUTS) && (n <= MAX_INPUTS);
    endfunction

endpackage

// File: rtl/dma_down_arb_rr_sel.sv
// Rotating-priority request selector: first request at or above i_ptr, with wrap.
module dma_down_arb_rr_sel
    import dma_down_arbiter_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned SW = sel_width(N)
)(
    input  logic [N-1:0]  i_req,
    input  logic [SW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [SW-1:0] o_idx,
    output logic          o_any
);

    logic [SW:0] w_pos;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_pos = '0;
        for (int unsigned k = 0; k < N; k++) begin
            // ptr < N and k < N, so one conditional subtract is a full modulo
            w_pos = {1'b0, i_ptr} + (SW+1)'(k);
            if (w_pos >= (SW+1)'(N)) w_pos = w_pos - (SW+1)'(N);
            if (!o_any && i_req[w_pos[SW-1:0]]) begin
                o_any               = 1'b1;
                o_gnt[w_pos[SW-1:0]] = 1'b1;
                o_idx               = w_pos[SW-1:0];
            end
        end
    end

endmodule

// File: rtl/dma_down_arbiter.sv
// Packet-atomic round-robin merge of INPUTS DMA down buses onto one registered bus.
// Optional per-input EOP packet counters are enabled by defining DMA_ARB_PKT_CNT_EN.
module dma_down_arbiter
    import dma_down_arbiter_pkg::*;
#(
    parameter int unsigned INPUTS     = 4,
    parameter int unsigned HDR_WIDTH  = 96,
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned CNT_WIDTH  = 32
)(
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic [INPUTS*HDR_WIDTH-1:0]  RX_DMA_HDR,
    input  logic [INPUTS*DATA_WIDTH-1:0] RX_DMA_DATA,
    input  logic [INPUTS-1:0]            RX_DMA_SOP,
    input  logic [INPUTS-1:0]            RX_DMA_EOP,
    input  logic [INPUTS-1:0]            RX_DMA_SRC_RDY,
    output logic [INPUTS-1:0]            RX_DMA_DST_RDY,
    output logic [HDR_WIDTH-1:0]         TX_DMA_HDR,
    output logic [DATA_WIDTH-1:0]        TX_DMA_DATA,
    output logic                         TX_DMA_SOP,
    output logic                         TX_DMA_EOP,
    output logic                         TX_DMA_SRC_RDY,
    input  logic                         TX_DMA_DST_RDY,
`ifdef DMA_ARB_PKT_CNT_EN
    input  logic                         CNT_CLR,
    output logic [INPUTS*CNT_WIDTH-1:0]  PKT_CNT,
`endif
    output logic [sel_width(INPUTS)-1:0] TX_DMA_SEL
);

    localparam int unsigned SW = sel_width(INPUTS);

    if (!inputs_in_range(INPUTS) || CNT_WIDTH < 1) begin : g_param_err
        $error("dma_down_arbiter: parameter out of range");
    end

    state_t                r_state;
    logic [SW-1:0]         r_ptr;
    logic [SW-1:0]         r_grant;
    logic                  r_tx_src_rdy;
    logic                  r_tx_sop;
    logic                  r_tx_eop;
    logic [SW-1:0]         r_tx_sel;
    logic [HDR_WIDTH-1:0]  r_tx_hdr;
    logic [DATA_WIDTH-1:0] r_tx_data;

    logic                  w_out_free;
    logic [INPUTS-1:0]     w_req;
    logic [INPUTS-1:0]     w_gnt;
    logic [SW-1:0]         w_win_idx;
    logic                  w_win_any;
    logic [INPUTS-1:0]     w_lock_oh;
    logic [INPUTS-1:0]     w_dst_rdy;
    logic [SW-1:0]         w_acc_idx;
    logic                  w_accept;
    logic                  w_acc_sop;
    logic                  w_acc_eop;
    logic [HDR_WIDTH-1:0]  w_acc_hdr;
    logic [DATA_WIDTH-1:0] w_acc_data;
    logic [SW-1:0]         w_ptr_next;

    assign w_req      = RX_DMA_SRC_RDY & RX_DMA_SOP;
    assign w_out_free = !r_tx_src_rdy || TX_DMA_DST_RDY;
    assign w_lock_oh  = {{(INPUTS-1){1'b0}}, 1'b1} << r_grant;

    dma_down_arb_rr_sel #(
        .N  (INPUTS),
        .SW (SW)
    ) u_rr_sel (
        .i_req (w_req),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_win_idx),
        .o_any (w_win_any)
    );

    always_comb begin
        w_dst_rdy = '0;
        w_acc_idx = '0;
        if (r_state == LOCKED) begin
            w_acc_idx = r_grant;
            if (w_out_free) w_dst_rdy = w_lock_oh;
        end else begin
            w_acc_idx = w_win_idx;
            if (w_out_free && w_win_any) w_dst_rdy = w_gnt;
        end
    end

    assign w_accept   = |(RX_DMA_SRC_RDY & w_dst_rdy);
    assign w_acc_sop  = RX_DMA_SOP[w_acc_idx];
    assign w_acc_eop  = RX_DMA_EOP[w_acc_idx];
    assign w_acc_hdr  = RX_DMA_HDR[32'(w_acc_idx)*HDR_WIDTH +: HDR_WIDTH];
    assign w_acc_data = RX_DMA_DATA[32'(w_acc_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign w_ptr_next = (32'(w_win_idx) == INPUTS - 1) ? '0 : w_win_idx + 1'b1;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_grant <= '0;
        end else if (w_accept) begin
            case (r_state)
                IDLE: begin
                    r_ptr <= w_ptr_next;
                    if (!w_acc_eop) begin
                        r_state <= LOCKED;
                        r_grant <= w_win_idx;
                    end
                end
                LOCKED: if (w_acc_eop) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_tx_src_rdy <= 1'b0;
            r_tx_sop     <= 1'b0;
            r_tx_eop     <= 1'b0;
            r_tx_sel     <= '0;
        end else if (w_out_free) begin
            r_tx_src_rdy <= w_accept;
            if (w_accept) begin
                r_tx_sop <= w_acc_sop;
                r_tx_eop <= w_acc_eop;
                r_tx_sel <= w_acc_idx;
            end
        end
    end

    // Payload needs no reset: it is only observed while TX_DMA_SRC_RDY is set
    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_tx_hdr  <= w_acc_hdr;
            r_tx_data <= w_acc_data;
        end
    end

`ifdef DMA_ARB_PKT_CNT_EN
    logic [CNT_WIDTH-1:0] r_cnt [INPUTS];

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int unsigned i = 0; i < INPUTS; i++) r_cnt[i] <= '0;
        end else if (CNT_CLR) begin
            for (int unsigned i = 0; i < INPUTS; i++) r_cnt[i] <= '0;
        end else if (w_accept && w_acc_eop) begin
            r_cnt[w_acc_idx] <= r_cnt[w_acc_idx] + 1'b1;
        end
    end

    for (genvar g = 0; g < INPUTS; g++) begin : g_cnt_out
        assign PKT_CNT[g*CNT_WIDTH +: CNT_WIDTH] = r_cnt[g];
    end
`endif

    assign RX_DMA_DST_RDY = w_dst_rdy;
    assign TX_DMA_HDR     = r_tx_hdr;
    assign TX_DMA_DATA    = r_tx_data;
    assign TX_DMA_SOP     = r_tx_sop;
    assign TX_DMA_EOP     = r_tx_eop;
    assign TX_DMA_SRC_RDY = r_tx_src_rdy;
    assign TX_DMA_SEL     = r_tx_sel;

endmodule

// File: tb/tb_dma_down_arbiter.sv
// Directed bench for dma_down_arbiter: per-cycle vector table plus packet sequences.
// Counter checks are compiled in only when DMA_ARB_PKT_CNT_EN is defined.
module tb_dma_down_arbiter;

    localparam int N  = 4;
    localparam int HW = 16;
    localparam int DW = 32;
    localparam int CW = 8;

    logic            CLK = 1'b0;
    logic            RESET;
    logic [N*HW-1:0] RX_DMA_HDR;
    logic [N*DW-1:0] RX_DMA_DATA;
    logic [N-1:0]    RX_DMA_SOP;
    logic [N-1:0]    RX_DMA_EOP;
    logic [N-1:0]    RX_DMA_SRC_RDY;
    logic [N-1:0]    RX_DMA_DST_RDY;
    logic [HW-1:0]   TX_DMA_HDR;
    logic [DW-1:0]   TX_DMA_DATA;
    logic            TX_DMA_SOP;
    logic            TX_DMA_EOP;
    logic            TX_DMA_SRC_RDY;
    logic            TX_DMA_DST_RDY;
    logic [1:0]      TX_DMA_SEL;
`ifdef DMA_ARB_PKT_CNT_EN
    logic            CNT_CLR;
    logic [N*CW-1:0] PKT_CNT;
`endif

    dma_down_arbiter #(
        .INPUTS     (N),
        .HDR_WIDTH  (HW),
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .RX_DMA_HDR     (RX_DMA_HDR),
        .RX_DMA_DATA    (RX_DMA_DATA),
        .RX_DMA_SOP     (RX_DMA_SOP),
        .RX_DMA_EOP     (RX_DMA_EOP),
        .RX_DMA_SRC_RDY (RX_DMA_SRC_RDY),
        .RX_DMA_DST_RDY (RX_DMA_DST_RDY),
        .TX_DMA_HDR     (TX_DMA_HDR),
        .TX_DMA_DATA    (TX_DMA_DATA),
        .TX_DMA_SOP     (TX_DMA_SOP),
        .TX_DMA_EOP     (TX_DMA_EOP),
        .TX_DMA_SRC_RDY (TX_DMA_SRC_RDY),
        .TX_DMA_DST_RDY (TX_DMA_DST_RDY),
`ifdef DMA_ARB_PKT_CNT_EN
        .CNT_CLR        (CNT_CLR),
        .PKT_CNT        (PKT_CNT),
`endif
        .TX_DMA_SEL     (TX_DMA_SEL)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic [3:0] src;
        logic [3:0] sop;
        logic [3:0] eop;
        logic       txrdy;
        logic [3:0] exp_dst;
        logic       exp_src;
        logic [1:0] exp_sel;
        logic       exp_sop;
        logic       exp_eop;
    } vec_t;

    typedef struct packed {
        logic          sop;
        logic          eop;
        logic [HW-1:0] hdr;
        logic [DW-1:0] data;
    } word_t;

    word_t      src_mem [N][16];
    int         src_len [N];
    int         src_pos [N];
    word_t      exp_mem [64];
    logic [1:0] exp_sel [64];
    int         exp_len, exp_pos;
    bit         started, hold_pending;
    int         bubbles;
    logic [52:0] held;

    function automatic word_t mk(input int i, input int pkt, input int w, input int n);
        word_t x;
        x.sop  = (w == 0);
        x.eop  = (w == n - 1);
        x.hdr  = {4'(i), 4'(pkt), 8'(w)};
        x.data = {x.hdr, ~x.hdr};
        return x;
    endfunction

    task automatic add_pkt(input int i, input int pkt, input int n);
        for (int w = 0; w < n; w++) begin
            src_mem[i][src_len[i]] = mk(i, pkt, w, n);
            src_len[i]++;
        end
    endtask

    task automatic expect_pkt(input int i, input int pkt, input int n);
        for (int w = 0; w < n; w++) begin
            exp_mem[exp_len] = mk(i, pkt, w, n);
            exp_sel[exp_len] = 2'(i);
            exp_len++;
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            src_len[i] = 0;
            src_pos[i] = 0;
        end
        exp_len = 0; exp_pos = 0;
        started = 0; hold_pending = 0; bubbles = 0;
    endtask

    function automatic bit all_done();
        bit d = (exp_pos == exp_len);
        for (int i = 0; i < N; i++) if (src_pos[i] != src_len[i]) d = 0;
        return d;
    endfunction

    // mode 0: TX ready always 1; mode 1: TX ready pattern 1,0,0,1
    task automatic run(input int max_cyc, input int mode, input bit must_finish, input string tag);
        logic [3:0] pat;
        logic [N-1:0] acc;
        pat = 4'b1001;
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            @(negedge CLK);
            TX_DMA_DST_RDY = (mode == 0) ? 1'b1 : pat[cyc % 4];
            for (int i = 0; i < N; i++) begin
                if (src_pos[i] < src_len[i]) begin
                    RX_DMA_SRC_RDY[i]        = 1'b1;
                    RX_DMA_SOP[i]            = src_mem[i][src_pos[i]].sop;
                    RX_DMA_EOP[i]            = src_mem[i][src_pos[i]].eop;
                    RX_DMA_HDR[i*HW +: HW]   = src_mem[i][src_pos[i]].hdr;
                    RX_DMA_DATA[i*DW +: DW]  = src_mem[i][src_pos[i]].data;
                end else begin
                    RX_DMA_SRC_RDY[i] = 1'b0;
                    RX_DMA_SOP[i]     = 1'b0;
                    RX_DMA_EOP[i]     = 1'b0;
                end
            end
            #1;
            if (hold_pending)
                chk({tag, "_hold"}, 64'({TX_DMA_SRC_RDY, TX_DMA_SEL, TX_DMA_SOP, TX_DMA_EOP, TX_DMA_HDR, TX_DMA_DATA}), 64'(held));
            hold_pending = 0;
            if (TX_DMA_SRC_RDY && TX_DMA_DST_RDY) begin
                if (exp_pos < exp_len)
                    chk($sformatf("%s_word%0d", tag, exp_pos),
                        64'({TX_DMA_SEL, TX_DMA_SOP, TX_DMA_EOP, TX_DMA_HDR, TX_DMA_DATA}),
                        64'({exp_sel[exp_pos], exp_mem[exp_pos].sop, exp_mem[exp_pos].eop,
                             exp_mem[exp_pos].hdr, exp_mem[exp_pos].data}));
                else
                    chk({tag, "_extra_word"}, 64'(TX_DMA_HDR), 64'hFFFF_FFFF_FFFF_FFFF);
                exp_pos++;
                started = 1;
            end else if (TX_DMA_SRC_RDY) begin
                hold_pending = 1;
                held = {TX_DMA_SRC_RDY, TX_DMA_SEL, TX_DMA_SOP, TX_DMA_EOP, TX_DMA_HDR, TX_DMA_DATA};
                chk({tag, "_bp_dst"}, 64'(RX_DMA_DST_RDY), 64'd0);
            end else if (started && exp_pos < exp_len) begin
                bubbles++;
            end
            acc = RX_DMA_SRC_RDY & RX_DMA_DST_RDY;
            @(posedge CLK);
            for (int i = 0; i < N; i++) if (acc[i]) src_pos[i]++;
            if (all_done()) break;
        end
        if (must_finish) begin
            chk({tag, "_complete"}, 64'(all_done()), 64'd1);
            if (mode == 0) chk({tag, "_bubbles"}, 64'(bubbles), 64'd0);
        end
    endtask

    task automatic reset_dut();
        @(negedge CLK);
        RESET          = 1'b0;
        RX_DMA_SRC_RDY = '0;
        RX_DMA_SOP     = '0;
        RX_DMA_EOP     = '0;
        TX_DMA_DST_RDY = 1'b1;
`ifdef DMA_ARB_PKT_CNT_EN
        CNT_CLR        = 1'b0;
`endif
        #1;
        chk("rst_tx_src_rdy", 64'(TX_DMA_SRC_RDY), 64'd0);
        chk("rst_rx_dst_rdy", 64'(RX_DMA_DST_RDY), 64'd0);
        chk("rst_tx_sel",     64'(TX_DMA_SEL),     64'd0);
        chk("rst_tx_sop_eop", 64'({TX_DMA_SOP, TX_DMA_EOP}), 64'd0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        #1;
        chk("post_rst_idle", 64'({TX_DMA_SRC_RDY, RX_DMA_DST_RDY, TX_DMA_SEL}), 64'd0);
    endtask

    vec_t vecs [13];

    initial begin
        RESET          = 1'b1;
        RX_DMA_HDR     = '0;
        RX_DMA_DATA    = '0;
        RX_DMA_SOP     = '0;
        RX_DMA_EOP     = '0;
        RX_DMA_SRC_RDY = '0;
        TX_DMA_DST_RDY = 1'b1;
`ifdef DMA_ARB_PKT_CNT_EN
        CNT_CLR        = 1'b0;
`endif
        //            src      sop      eop      rdy   dst      src  sel    sop   eop
        vecs[0]  = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[1]  = '{4'b1010, 4'b1010, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1, 1'b1};
        vecs[2]  = '{4'b1010, 4'b1010, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1, 1'b1};
        vecs[3]  = '{4'b1010, 4'b1010, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1, 1'b1};
        vecs[4]  = '{4'b1010, 4'b1010, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1, 1'b1};
        vecs[5]  = '{4'b1010, 4'b1010, 4'b1010, 1'b0, 4'b0000, 1'b1, 2'd3, 1'b1, 1'b1};
        vecs[6]  = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[7]  = '{4'b0101, 4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1, 1'b0};
        vecs[8]  = '{4'b0100, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b1, 1'b0};
        vecs[9]  = '{4'b0110, 4'b0010, 4'b0010, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0, 1'b0};
        vecs[10] = '{4'b0110, 4'b0010, 4'b0110, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0, 1'b1};
        vecs[11] = '{4'b0010, 4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1, 1'b1};
        vecs[12] = '{4'b1000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0};

        reset_dut();

        RX_DMA_HDR  = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
        RX_DMA_DATA = {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
        for (int v = 0; v < 13; v++) begin
            logic [15:0] eh;
            @(negedge CLK);
            RX_DMA_SRC_RDY = vecs[v].src;
            RX_DMA_SOP     = vecs[v].sop;
            RX_DMA_EOP     = vecs[v].eop;
            TX_DMA_DST_RDY = vecs[v].txrdy;
            #1;
            chk($sformatf("vec%0d_dst_rdy", v), 64'(RX_DMA_DST_RDY), 64'(vecs[v].exp_dst));
            @(posedge CLK);
            #1;
            eh = 16'h1000 + {14'd0, vecs[v].exp_sel};
            if (vecs[v].exp_src)
                chk($sformatf("vec%0d_tx", v),
                    64'({TX_DMA_SRC_RDY, TX_DMA_SEL, TX_DMA_SOP, TX_DMA_EOP, TX_DMA_HDR}),
                    64'({1'b1, vecs[v].exp_sel, vecs[v].exp_sop, vecs[v].exp_eop, eh}));
            else
                chk($sformatf("vec%0d_tx_src_rdy", v), 64'(TX_DMA_SRC_RDY), 64'd0);
        end

        // Four 3-word packets granted 0,1,2,3 back to back
        reset_dut();
        clear_model();
        for (int i = 0; i < N; i++) add_pkt(i, 0, 3);
        for (int i = 0; i < N; i++) expect_pkt(i, 0, 3);
        run(40, 0, 1, "rr4");

        // Input 1 SOP arrives while input 2 is mid-packet; pointer is 0 here
        clear_model();
        add_pkt(2, 1, 4);
        expect_pkt(2, 1, 4);
        expect_pkt(1, 1, 2);
        run(2, 0, 0, "lock");
        add_pkt(1, 1, 2);
        run(40, 0, 1, "lock");

        // Pointer now 2: input 3 before input 0, TX ready toggling 1,0,0,1
        clear_model();
        add_pkt(0, 2, 3);
        add_pkt(3, 2, 3);
        expect_pkt(3, 2, 3);
        expect_pkt(0, 2, 3);
        run(60, 1, 1, "bp");

`ifdef DMA_ARB_PKT_CNT_EN
        reset_dut();
        clear_model();
        for (int p = 0; p < 5; p++) add_pkt(0, p, 1);
        for (int p = 0; p < 2; p++) add_pkt(3, p, 1);
        expect_pkt(0, 0, 1); expect_pkt(3, 0, 1);
        expect_pkt(0, 1, 1); expect_pkt(3, 1, 1);
        expect_pkt(0, 2, 1); expect_pkt(0, 3, 1); expect_pkt(0, 4, 1);
        run(40, 0, 1, "cnt");
        @(negedge CLK);
        RX_DMA_SRC_RDY = '0;
        #1;
        chk("cnt0_before_clr", 64'(PKT_CNT[0*CW +: CW]), 64'd5);
        chk("cnt3_before_clr", 64'(PKT_CNT[3*CW +: CW]), 64'd2);
        @(negedge CLK);
        RX_DMA_SRC_RDY = 4'b0001;
        RX_DMA_SOP     = 4'b0001;
        RX_DMA_EOP     = 4'b0001;
        TX_DMA_DST_RDY = 1'b1;
        CNT_CLR        = 1'b1;
        #1;
        chk("cnt_clr_accept", 64'(RX_DMA_DST_RDY), 64'b0001);
        @(posedge CLK);
        @(negedge CLK);
        CNT_CLR        = 1'b0;
        RX_DMA_SRC_RDY = '0;
        #1;
        chk("cnt0_after_clr", 64'(PKT_CNT[0*CW +: CW]), 64'd0);
        chk("cnt3_after_clr", 64'(PKT_CNT[3*CW +: CW]), 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
